// File: rtl/booth_mul64_core.sv
// Iterative 64x64 signed multiplier, radix-2 Booth, one iteration per clock.
// Starts from IDLE or DONE, runs 64 EXEC iterations, then holds the 128-bit product in DONE.
module booth_mul64_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  multiplicand,
  input  logic [63:0]  multiplier,
  output logic         busy,
  output logic         op_done,
  output logic [127:0] result
);

  // Bit 0 of the state is busy and bit 1 is op_done, so both outputs come straight from flops.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]   state_r;
  logic [63:0]  m_reg_r;
  logic [63:0]  q_reg_r;
  logic         q_m1_r;
  logic [64:0]  acc_r;
  logic [5:0]   cnt_r;
  logic [127:0] result_r;

  logic [64:0]  m_ext_s;
  logic [64:0]  addsub_s;
  logic [64:0]  sum_s;
  logic [64:0]  acc_nxt_s;
  logic [63:0]  q_nxt_s;
  logic         q_m1_nxt_s;
  logic         start_ok_s;

  // 2:1 selection stage, widened to 65 bits to carry the accumulator guard bit.
  function automatic logic [64:0] sel2_65(input logic sel, input logic [64:0] d0,
                                          input logic [64:0] d1);
    logic [64:0] y;
    if (sel) begin
      y = d1;
    end else begin
      y = d0;
    end
    return y;
  endfunction

  // Booth recode, add/subtract, select, and arithmetic right shift of {acc, Q, q_m1}.
  always_comb begin
    m_ext_s = {m_reg_r[63], m_reg_r};
    if (q_reg_r[0]) begin
      addsub_s = acc_r - m_ext_s;
    end else begin
      addsub_s = acc_r + m_ext_s;
    end
    sum_s      = sel2_65(q_reg_r[0] ^ q_m1_r, acc_r, addsub_s);
    acc_nxt_s  = {sum_s[64], sum_s[64:1]};
    q_nxt_s    = {sum_s[0], q_reg_r[63:1]};
    q_m1_nxt_s = q_reg_r[0];
    start_ok_s = op_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // Control state, operand registers, iteration datapath and the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      m_reg_r  <= 64'd0;
      q_reg_r  <= 64'd0;
      q_m1_r   <= 1'b0;
      acc_r    <= 65'd0;
      cnt_r    <= 6'd0;
      result_r <= 128'd0;
    end else if (op_clear) begin
      state_r  <= ST_IDLE;
      m_reg_r  <= 64'd0;
      q_reg_r  <= 64'd0;
      q_m1_r   <= 1'b0;
      acc_r    <= 65'd0;
      cnt_r    <= 6'd0;
      result_r <= 128'd0;
    end else if (start_ok_s) begin
      state_r <= ST_EXEC;
      m_reg_r <= multiplicand;
      q_reg_r <= multiplier;
      q_m1_r  <= 1'b0;
      acc_r   <= 65'd0;
      cnt_r   <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_EXEC: begin
          acc_r  <= acc_nxt_s;
          q_reg_r <= q_nxt_s;
          q_m1_r <= q_m1_nxt_s;
          cnt_r  <= cnt_r + 6'd1;
          // The product is captured from the post-shift values of the last iteration.
          if (cnt_r == 6'd63) begin
            state_r  <= ST_DONE;
            result_r <= {acc_nxt_s[63:0], q_nxt_s};
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_DONE: state_r <= ST_DONE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign busy    = state_r[0];
  assign op_done = state_r[1];
  assign result  = result_r;

endmodule
